// File: rtl/phys_reg_reclaim.sv
// -----------------------------------------------------------------------------
// phys_reg_reclaim
//   In-order retirement / reclaim buffer on the return side of the physical
//   register free list. Each dispatched instruction records its rename
//   (arch_dest, new_preg, old_preg). Execution marks entries done by tag. The
//   oldest done entry retires once per cycle. On retire, old_preg is handed
//   back to the free list and the committed mapping is published.
//
// Configuration
//   RECLAIM_FLUSH_EN : when defined, adds the flush port and a WALK state.
//                      WALK squashes entries youngest-first and returns their
//                      new_preg. When undefined, the FSM stays in IDLE and
//                      return_reg only ever carries old_preg from commits.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   dispatch_*           rename record offered / accepted (valid/ready)
//   dispatch_tag         entry tag (tail index) used by an accept this cycle
//   complete_valid/tag   marks an in-flight entry done
//   flush                squash every entry (RECLAIM_FLUSH_EN only)
//   return_flag/reg      registered pulse: physical register freed
//   retire_valid/...     registered pulse: committed architectural mapping
// -----------------------------------------------------------------------------
`default_nettype none

module phys_reg_reclaim #(
  parameter  int DEPTH  = 8,
  parameter  int PREG_W = 5,
  parameter  int AREG_W = 5,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic              dispatch_has_dest,
  input  logic [AREG_W-1:0] dispatch_arch_dest,
  input  logic [PREG_W-1:0] dispatch_new_preg,
  input  logic [PREG_W-1:0] dispatch_old_preg,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
`ifdef RECLAIM_FLUSH_EN
  input  logic              flush,
`endif
  output logic              return_flag,
  output logic [PREG_W-1:0] return_reg,
  output logic              retire_valid,
  output logic [AREG_W-1:0] retire_arch_dest,
  output logic [PREG_W-1:0] retire_preg
);

  localparam int PTR_W = TAG_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef enum logic {ST_IDLE, ST_WALK} state_e;

  // Control state
  state_e           state_q, state_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Entry payload
  logic [DEPTH-1:0] has_dest_q;
  logic [AREG_W-1:0] arch_dest_q [DEPTH];
  logic [PREG_W-1:0] new_preg_q  [DEPTH];
  logic [PREG_W-1:0] old_preg_q  [DEPTH];

  // Registered outputs
  logic              return_flag_q;
  logic [PREG_W-1:0] return_reg_q;
  logic              retire_valid_q;
  logic [AREG_W-1:0] retire_arch_dest_q;
  logic [PREG_W-1:0] retire_preg_q;

  ptr_t count;
  ptr_t tail_m1;
  tag_t head_idx;
  tag_t tail_idx;
  tag_t pop_idx;
  logic accept;
  logic commit;
  logic flush_start;
  logic walk_pop;

  // The wrap bit makes count==DEPTH (full) distinct from count==0 (empty).
  assign count    = tail_q - head_q;
  assign tail_m1  = tail_q - ptr_t'(1);
  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign pop_idx  = tail_m1[TAG_W-1:0];

  // Ready looks only at the current count, so a commit in a full cycle
  // frees a slot for the next cycle, not this one.
  assign dispatch_ready = (count != ptr_t'(DEPTH)) && (state_q == ST_IDLE);
  assign dispatch_tag   = tail_idx;
  assign accept         = dispatch_valid && dispatch_ready;

`ifdef RECLAIM_FLUSH_EN
  assign flush_start = (state_q == ST_IDLE) && flush && (count != '0);
  assign walk_pop    = (state_q == ST_WALK);
`else
  assign flush_start = 1'b0;
  assign walk_pop    = 1'b0;
`endif

  // A flush wins over a same-cycle commit: the head gets squashed, not retired.
  // done_q is the registered bit, so a completion of the head commits next cycle.
  assign commit = (state_q == ST_IDLE) && !flush_start &&
                  valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;

    if ((state_q == ST_IDLE) && complete_valid && valid_q[complete_tag]) begin
      done_d[complete_tag] = 1'b1;
    end

    if (commit) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + ptr_t'(1);
    end

    // head and tail slots differ here: commit needs non-empty, accept non-full.
    if (accept) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + ptr_t'(1);
    end

    if (flush_start) begin
      state_d = ST_WALK;
    end

    // Squash walk pops the youngest entry each cycle until the buffer is empty.
    if (walk_pop) begin
      valid_d[pop_idx] = 1'b0;
      done_d[pop_idx]  = 1'b0;
      tail_d           = tail_m1;
      if (tail_m1 == head_q) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q            <= ST_IDLE;
      head_q             <= '0;
      tail_q             <= '0;
      valid_q            <= '0;
      done_q             <= '0;
      return_flag_q      <= 1'b0;
      return_reg_q       <= '0;
      retire_valid_q     <= 1'b0;
      retire_arch_dest_q <= '0;
      retire_preg_q      <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      retire_valid_q <= commit;

      if (commit) begin
        return_flag_q      <= has_dest_q[head_idx];
        return_reg_q       <= old_preg_q[head_idx];
        retire_arch_dest_q <= arch_dest_q[head_idx];
        retire_preg_q      <= new_preg_q[head_idx];
      end else if (walk_pop) begin
        return_flag_q <= has_dest_q[pop_idx];
        return_reg_q  <= new_preg_q[pop_idx];
      end else begin
        return_flag_q <= 1'b0;
      end
    end
  end

  // NOTE: payload storage has no reset; valid_q alone decides whether a slot
  // is meaningful, so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      has_dest_q[tail_idx]  <= dispatch_has_dest;
      arch_dest_q[tail_idx] <= dispatch_arch_dest;
      new_preg_q[tail_idx]  <= dispatch_new_preg;
      old_preg_q[tail_idx]  <= dispatch_old_preg;
    end
  end

  assign return_flag      = return_flag_q;
  assign return_reg       = return_reg_q;
  assign retire_valid     = retire_valid_q;
  assign retire_arch_dest = retire_arch_dest_q;
  assign retire_preg      = retire_preg_q;

endmodule

`default_nettype wire

// File: tb/tb_phys_reg_reclaim.sv
// -----------------------------------------------------------------------------
// tb_phys_reg_reclaim
//   Directed scenarios followed by randomized traffic. A queue-based reference
//   model of the in-flight instructions (oldest first) predicts every output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_phys_reg_reclaim;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 5;
  localparam int AREG_W = 5;
  localparam int TAG_W  = $clog2(DEPTH);

  logic              clk;
  logic              reset;
  logic              dispatch_valid;
  logic              dispatch_ready;
  logic              dispatch_has_dest;
  logic [AREG_W-1:0] dispatch_arch_dest;
  logic [PREG_W-1:0] dispatch_new_preg;
  logic [PREG_W-1:0] dispatch_old_preg;
  logic [TAG_W-1:0]  dispatch_tag;
  logic              complete_valid;
  logic [TAG_W-1:0]  complete_tag;
`ifdef RECLAIM_FLUSH_EN
  logic              flush;
`endif
  logic              return_flag;
  logic [PREG_W-1:0] return_reg;
  logic              retire_valid;
  logic [AREG_W-1:0] retire_arch_dest;
  logic [PREG_W-1:0] retire_preg;

  phys_reg_reclaim #(
    .DEPTH  (DEPTH),
    .PREG_W (PREG_W),
    .AREG_W (AREG_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_has_dest  (dispatch_has_dest),
    .dispatch_arch_dest (dispatch_arch_dest),
    .dispatch_new_preg  (dispatch_new_preg),
    .dispatch_old_preg  (dispatch_old_preg),
    .dispatch_tag       (dispatch_tag),
    .complete_valid     (complete_valid),
    .complete_tag       (complete_tag),
`ifdef RECLAIM_FLUSH_EN
    .flush              (flush),
`endif
    .return_flag        (return_flag),
    .return_reg         (return_reg),
    .retire_valid       (retire_valid),
    .retire_arch_dest   (retire_arch_dest),
    .retire_preg        (retire_preg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: queue of in-flight instructions, oldest at index 0.
  // ---------------------------------------------------------------------------
  typedef struct {
    int tag;
    bit hd;
    int arch;
    int newp;
    int oldp;
    bit done;
  } entry_t;

  entry_t m_q[$];
  int     tail_tag;
  bit     walking;
  bit     exp_ret_valid;
  bit     exp_ret_flag;
  int     exp_ret_reg;
  int     exp_arch;
  int     exp_preg;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    tail_tag      = 0;
    walking       = 1'b0;
    exp_ret_valid = 1'b0;
    exp_ret_flag  = 1'b0;
    exp_ret_reg   = 0;
    exp_arch      = 0;
    exp_preg      = 0;
  endtask

  task automatic set_idle();
    dispatch_valid = 1'b0;
    complete_valid = 1'b0;
`ifdef RECLAIM_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs
  // mid-cycle, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    bit     commit_go;
    bit     flush_go;
    bit     take;
    entry_t e;
    @(negedge clk);
    check("dispatch_ready", dispatch_ready, 32'((m_q.size() < DEPTH) && !walking));
    check("dispatch_tag", 32'(dispatch_tag), 32'(tail_tag));
    if (reset) begin
      model_reset();
    end else if (walking) begin
      e = m_q.pop_back();
      tail_tag      = (tail_tag + DEPTH - 1) % DEPTH;
      exp_ret_valid = 1'b0;
      exp_ret_flag  = e.hd;
      exp_ret_reg   = e.newp;
      if (m_q.size() == 0) walking = 1'b0;
    end else begin
      flush_go = 1'b0;
`ifdef RECLAIM_FLUSH_EN
      flush_go = flush && (m_q.size() > 0);
`endif
      commit_go = !flush_go && (m_q.size() > 0) && m_q[0].done;
      take      = dispatch_valid && (m_q.size() < DEPTH);
      if (complete_valid) begin
        foreach (m_q[i]) if (m_q[i].tag == int'(complete_tag)) m_q[i].done = 1'b1;
      end
      exp_ret_valid = commit_go;
      exp_ret_flag  = 1'b0;
      if (commit_go) begin
        e = m_q.pop_front();
        exp_ret_flag = e.hd;
        exp_ret_reg  = e.oldp;
        exp_arch     = e.arch;
        exp_preg     = e.newp;
      end
      if (take) begin
        e.tag  = tail_tag;
        e.hd   = dispatch_has_dest;
        e.arch = int'(dispatch_arch_dest);
        e.newp = int'(dispatch_new_preg);
        e.oldp = int'(dispatch_old_preg);
        e.done = 1'b0;
        m_q.push_back(e);
        tail_tag = (tail_tag + 1) % DEPTH;
      end
      walking = flush_go;
    end
    @(posedge clk);
    #1;
    check("retire_valid", 32'(retire_valid), 32'(exp_ret_valid));
    check("return_flag", 32'(return_flag), 32'(exp_ret_flag));
    check("return_reg", 32'(return_reg), 32'(exp_ret_reg));
    check("retire_arch_dest", 32'(retire_arch_dest), 32'(exp_arch));
    check("retire_preg", 32'(retire_preg), 32'(exp_preg));
  endtask

  task automatic disp(input bit hd, input int arch, input int newp, input int oldp);
    set_idle();
    dispatch_valid     = 1'b1;
    dispatch_has_dest  = hd;
    dispatch_arch_dest = AREG_W'(arch);
    dispatch_new_preg  = PREG_W'(newp);
    dispatch_old_preg  = PREG_W'(oldp);
    cycle();
    set_idle();
  endtask

  task automatic comp(input int tag);
    set_idle();
    complete_valid = 1'b1;
    complete_tag   = TAG_W'(tag);
    cycle();
    set_idle();
  endtask

  task automatic idle_cycle();
    set_idle();
    cycle();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    set_idle();
    dispatch_has_dest  = 1'b0;
    dispatch_arch_dest = '0;
    dispatch_new_preg  = '0;
    dispatch_old_preg  = '0;
    complete_tag       = '0;

    // Power-on reset and reset-state checks.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_ready", 32'(dispatch_ready), 32'd1);
    check("rst_tag", 32'(dispatch_tag), 32'd0);
    check("rst_retire_valid", 32'(retire_valid), 32'd0);
    check("rst_return_flag", 32'(return_flag), 32'd0);
    check("rst_return_reg", 32'(return_reg), 32'd0);
    check("rst_retire_arch", 32'(retire_arch_dest), 32'd0);
    check("rst_retire_preg", 32'(retire_preg), 32'd0);

    // 1: single entry, retire two cycles after completion.
    disp(1'b1, 3, 9, 3);
    comp(0);
    check("t1_not_yet", 32'(retire_valid), 32'd0);
    idle_cycle();
    check("t1_retire_valid", 32'(retire_valid), 32'd1);
    check("t1_return_flag", 32'(return_flag), 32'd1);
    check("t1_return_reg", 32'(return_reg), 32'd3);
    check("t1_arch", 32'(retire_arch_dest), 32'd3);
    check("t1_preg", 32'(retire_preg), 32'd9);
    idle_cycle();
    check("t1_pulse_end", 32'(retire_valid), 32'd0);

    // 2: fill, stall on the ninth, one commit frees a slot, tag wraps to 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) disp(1'b1, i, 16 + i, i);
    check("t2_full", 32'(dispatch_ready), 32'd0);
    disp(1'b1, 30, 30, 30);
    check("t2_still_full", 32'(dispatch_ready), 32'd0);
    comp(0);
    check("t2_full_after_comp", 32'(dispatch_ready), 32'd0);
    idle_cycle();
    check("t2_ready_again", 32'(dispatch_ready), 32'd1);
    check("t2_wrap_tag", 32'(dispatch_tag), 32'd0);
    check("t2_retired_preg", 32'(retire_preg), 32'd16);
    disp(1'b1, 1, 2, 3);
    check("t2_full_again", 32'(dispatch_ready), 32'd0);

    // 3: out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) disp(1'b1, i + 1, 20 + i, i + 4);
    comp(2);
    comp(1);
    idle_cycle();
    check("t3_wait_head", 32'(retire_valid), 32'd0);
    comp(0);
    check("t3_wait_vis", 32'(retire_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      check("t3_in_order_valid", 32'(retire_valid), 32'd1);
      check("t3_in_order_preg", 32'(retire_preg), 32'(20 + k));
    end

    // 4: entry without destination retires but frees nothing.
    do_reset();
    disp(1'b0, 7, 8, 9);
    comp(0);
    idle_cycle();
    check("t4_retire_valid", 32'(retire_valid), 32'd1);
    check("t4_return_flag", 32'(return_flag), 32'd0);
    check("t4_preg", 32'(retire_preg), 32'd8);

    // 5: completion of an invalid entry changes nothing.
    comp(1);
    idle_cycle();
    check("t5_no_retire", 32'(retire_valid), 32'd0);
    check("t5_tag_unchanged", 32'(dispatch_tag), 32'd1);
    disp(1'b1, 5, 6, 7);
    repeat (2) idle_cycle();
    check("t5_stale_done", 32'(retire_valid), 32'd0);

`ifdef RECLAIM_FLUSH_EN
    // 6: flush walks youngest-first returning new_preg.
    do_reset();
    for (int i = 0; i < 3; i++) disp(1'b1, i, 10 + i, i);
    flush = 1'b1;
    cycle();
    set_idle();
    check("t6_walk_ready", 32'(dispatch_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      check("t6_return_flag", 32'(return_flag), 32'd1);
      check("t6_return_reg", 32'(return_reg), 32'(12 - k));
      check("t6_no_retire", 32'(retire_valid), 32'd0);
      check("t6_ready", 32'(dispatch_ready), (k == 2) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized traffic against the model, including mid-stream resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      reset              = ($urandom_range(0, 299) == 0);
      dispatch_valid     = ($urandom_range(0, 9) < 6);
      dispatch_has_dest  = ($urandom_range(0, 3) != 0);
      dispatch_arch_dest = AREG_W'($urandom_range(0, 31));
      dispatch_new_preg  = PREG_W'($urandom_range(0, 31));
      dispatch_old_preg  = PREG_W'($urandom_range(0, 31));
      complete_valid     = ($urandom_range(0, 9) < 6);
      complete_tag       = TAG_W'($urandom_range(0, DEPTH - 1));
`ifdef RECLAIM_FLUSH_EN
      flush = ($urandom_range(0, 59) == 0);
`endif
      cycle();
    end
    reset = 1'b0;
    set_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
